// File: rtl/mem_access_unit_if.sv
// Data-memory port of the load/store unit: one request/ready handshake with
// word address, byte enables and lane-replicated write data.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the ALU and data memory. It launches one memory
// access per load/store instruction, stalls the core until that access
// finishes, and extends load data for write-back. Misaligned, illegal and
// timed-out accesses are aborted and reported with ErrValid/ErrCode.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a load/store; decode and launch or reject it
// REQ   | mem_req high, request fields frozen, timeout timer running
// DONE  | access finished (or aborted); core advances on this edge
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        ALUResult,
    input  logic [31:0]        ReadData2,
    input  logic [2:0]         funct3,
    input  logic               MemRead,
    input  logic               MemWrite,
    output logic               Stall,
    output logic [31:0]        LoadData,
    output logic               ErrValid,
    output logic [1:0]         ErrCode,
    mem_access_unit_if.master  mem
);

    localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] tmo_cnt_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  f3_q;

    logic        start;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        launch;
    logic        capture;
    logic [1:0]  err_d;

    // Pick the addressed lane out of the read word and sign/zero extend it.
    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  lo,
                                            input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign start = MemRead | MemWrite;

    // Access decode: legality, alignment, lane enables and replicated store data.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = ReadData2;
        if (MemRead && MemWrite)
            illegal = 1'b1;
        else if (MemRead && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
            illegal = 1'b1;
        else if (MemWrite && !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010))
            illegal = 1'b1;
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ALUResult[1:0];
                wdata_d = {4{ReadData2[7:0]}};
            end
            2'b01: begin
                misaligned = ALUResult[0];
                be_d       = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{ReadData2[15:0]}};
            end
            default: begin
                misaligned = (ALUResult[1:0] != 2'b00);
            end
        endcase
    end

    // Next-state logic plus the stall and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        Stall   = 1'b0;
        launch  = 1'b0;
        capture = 1'b0;
        err_d   = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    Stall = 1'b1;
                    if (illegal) begin
                        err_d   = ERR_ILL;
                        state_d = DONE;
                    end else if (misaligned) begin
                        err_d   = ERR_ALIGN;
                        state_d = DONE;
                    end else begin
                        launch  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem.mem_ready) begin
                    capture = ~mem.mem_we;
                    state_d = DONE;
                end else if (tmo_cnt_q == '0) begin
                    err_d   = ERR_TMO;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request fields are latched at launch and held untouched through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            addr_lo_q     <= '0;
            f3_q          <= '0;
        end else if (launch) begin
            mem.mem_we    <= MemWrite;
            mem.mem_addr  <= {ALUResult[31:2], 2'b00};
            mem.mem_be    <= be_d;
            mem.mem_wdata <= wdata_d;
            addr_lo_q     <= ALUResult[1:0];
            f3_q          <= funct3;
        end
    end

    // Timeout down-counter: loaded at launch, expires at zero without ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               tmo_cnt_q <= '0;
        else if (launch)          tmo_cnt_q <= TC_LOAD;
        else if (state_q == REQ)  tmo_cnt_q <= tmo_cnt_q - 1'b1;
    end

    // Load result only changes on a successful load completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       LoadData <= '0;
        else if (capture) LoadData <= extract(mem.mem_rdata, addr_lo_q, f3_q);
    end

    // Error pulse lands in DONE; the code is held until the next error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ErrValid <= 1'b0;
            ErrCode  <= ERR_NONE;
        end else begin
            ErrValid <= (err_d != ERR_NONE);
            if (err_d != ERR_NONE) ErrCode <= err_d;
        end
    end

    assign mem.mem_req = (state_q == REQ);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes the expected
// outcome of each instruction, a negedge monitor pops it when the access
// finishes (first non-stalled cycle) and compares.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResult, ReadData2;
    logic [2:0]  funct3;
    logic        MemRead, MemWrite;
    logic        Stall;
    logic [31:0] LoadData;
    logic        ErrValid;
    logic [1:0]  ErrCode;

    mem_access_unit_if mif ();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUResult (ALUResult),
        .ReadData2 (ReadData2),
        .funct3    (funct3),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Stall     (Stall),
        .LoadData  (LoadData),
        .ErrValid  (ErrValid),
        .ErrCode   (ErrCode),
        .mem       (mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [1:0]  ec;
        logic [31:0] ld;
        int          stall;
        int          req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_load;
    logic [1:0]  m_ec;
    int          cur_wait;
    logic [31:0] cur_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one instruction from the access rules.
    task automatic model(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2,
                         input int wt, input logic [31:0] rd, output exp_t e);
        int          sz;
        int          off;
        int          err;
        logic [31:0] mask, v;
        e.ev = 1'b0; e.req = 0; e.we = 1'b0; e.addr = '0; e.be = '0; e.wd = '0;
        err = 0;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        if ((r && w) || (r && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (w && f3 > 3'd2))
            err = 3;
        else if (a % sz != 0)
            err = 1;
        else begin
            e.req  = (wt < TO) ? wt + 1 : TO;
            e.we   = w;
            e.addr = a & 32'hFFFF_FFFC;
            e.be   = 4'(((1 << sz) - 1) << off);
            e.wd   = (sz == 1) ? {24'd0, rs2[7:0]} * 32'h0101_0101 :
                     (sz == 2) ? {16'd0, rs2[15:0]} * 32'h0001_0001 : rs2;
            if (wt >= TO)
                err = 2;
            else if (r) begin
                mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
                v    = (rd >> (8 * off)) & mask;
                if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
                m_load = v;
            end
        end
        if (err != 0) begin
            e.ev = 1'b1;
            m_ec = 2'(err);
        end
        e.ec    = m_ec;
        e.ld    = m_load;
        e.stall = 1 + e.req;
    endtask

    // Memory: ready after cur_wait wait states, junk read data otherwise.
    int k = 0;
    always @(posedge clk) begin
        #1;
        if (mif.mem_req) begin
            mif.mem_ready = (k == cur_wait);
            mif.mem_rdata = (k == cur_wait) ? cur_rdata : $urandom;
            k++;
        end else begin
            k = 0;
            mif.mem_ready = 1'b0;
            mif.mem_rdata = $urandom;
        end
    end

    // Monitor: count stall/request cycles, check field stability, score at DONE.
    int          st_cnt = 0, rq_cnt = 0;
    logic        prev_st = 1'b0, stable;
    logic        c_we;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_be;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            st_cnt = 0; rq_cnt = 0; prev_st = 1'b0;
        end else if (Stall) begin
            chk("errvalid_during_stall", 32'(ErrValid), 32'd0);
            st_cnt++;
            if (mif.mem_req) begin
                if (rq_cnt == 0) begin
                    c_we = mif.mem_we; c_addr = mif.mem_addr; c_be = mif.mem_be; c_wd = mif.mem_wdata;
                    stable = 1'b1;
                end else if (c_we !== mif.mem_we || c_addr !== mif.mem_addr ||
                             c_be !== mif.mem_be || c_wd !== mif.mem_wdata)
                    stable = 1'b0;
                rq_cnt++;
            end
            prev_st = 1'b1;
        end else if (prev_st) begin
            prev_st = 1'b0;
            if (q.size() == 0)
                chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("err_valid",    32'(ErrValid), 32'(e.ev));
                chk("err_code",     32'(ErrCode),  32'(e.ec));
                chk("load_data",    LoadData,      e.ld);
                chk("stall_cycles", 32'(st_cnt),   32'(e.stall));
                chk("req_cycles",   32'(rq_cnt),   32'(e.req));
                if (e.req > 0 && rq_cnt > 0) begin
                    chk("mem_we",     32'(c_we),   32'(e.we));
                    chk("mem_addr",   c_addr,      e.addr);
                    chk("mem_be",     32'(c_be),   32'(e.be));
                    chk("mem_wdata",  c_wd,        e.wd);
                    chk("req_stable", 32'(stable), 32'd1);
                end
            end
            st_cnt = 0; rq_cnt = 0;
        end else
            chk("errvalid_idle", 32'(ErrValid), 32'd0);
    end

    task automatic do_reset();
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        m_load = '0; m_ec = '0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present one instruction (called at posedge+1) and hold it until DONE.
    task automatic run_txn(input logic r, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rs2,
                           input int wt, input logic [31:0] rd);
        exp_t e;
        int   n;
        model(r, w, f3, a, rs2, wt, rd, e);
        q.push_back(e);
        cur_wait = wt; cur_rdata = rd;
        MemRead = r; MemWrite = w; funct3 = f3; ALUResult = a; ReadData2 = rs2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Stall && n < 40);
        if (Stall) begin
            chk("done_reached", 32'd0, 32'd1);
            do_reset();
        end else begin
            @(posedge clk);
            #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        ALUResult = $urandom; ReadData2 = $urandom; funct3 = 3'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3;
        logic       r, w;
        logic [2:0] legal_ld [5];
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0;
        ALUResult = '0; ReadData2 = '0;
        mif.mem_ready = 1'b0; mif.mem_rdata = '0;
        cur_wait = 0; cur_rdata = '0; m_load = '0; m_ec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall",     32'(Stall),         32'd0);
        chk("rst_loaddata",  LoadData,           32'd0);
        chk("rst_errvalid",  32'(ErrValid),      32'd0);
        chk("rst_errcode",   32'(ErrCode),       32'd0);
        chk("rst_mem_req",   32'(mif.mem_req),   32'd0);
        chk("rst_mem_we",    32'(mif.mem_we),    32'd0);
        chk("rst_mem_addr",  mif.mem_addr,       32'd0);
        chk("rst_mem_be",    32'(mif.mem_be),    32'd0);
        chk("rst_mem_wdata", mif.mem_wdata,      32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn(1, 0, 3'b010, 32'h100, 32'd0,        0,  32'hDEAD_BEEF);
        run_txn(1, 0, 3'b000, 32'h103, 32'd0,        1,  32'h80FF_1234);
        run_txn(1, 0, 3'b100, 32'h103, 32'd0,        0,  32'h80FF_1234);
        run_txn(0, 1, 3'b001, 32'h22,  32'h0000_ABCD, 3, 32'd0);
        run_txn(1, 0, 3'b010, 32'h101, 32'd0,        0,  32'h1111_1111);
        run_txn(1, 0, 3'b010, 32'h40,  32'd0,        10, 32'h2222_2222);
        run_txn(1, 0, 3'b001, 32'h46,  32'd0,        3,  32'h8001_7FFF);
        run_txn(1, 1, 3'b010, 32'h80,  32'd5,        0,  32'd0);
        run_txn(0, 1, 3'b100, 32'h84,  32'd5,        0,  32'd0);
        run_txn(1, 0, 3'b011, 32'h88,  32'd0,        0,  32'd0);
        run_txn(0, 1, 3'b010, 32'h90,  32'h1234_5678, 10, 32'd0);

        // Reset while a request is outstanding.
        cur_wait = 10; cur_rdata = 32'h5555_5555;
        MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h200;
        @(posedge clk);
        #1;
        chk("pre_reset_req", 32'(mif.mem_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0; MemRead = 1'b0;
        #1;
        chk("async_rst_mem_req",  32'(mif.mem_req), 32'd0);
        chk("async_rst_stall",    32'(Stall),       32'd0);
        chk("async_rst_loaddata", LoadData,         32'd0);
        m_load = '0; m_ec = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn(1, 0, 3'b010, 32'h300, 32'd0, 0, 32'hCAFE_F00D);

        for (int i = 0; i < 150; i++) begin
            int kind;
            kind = $urandom_range(0, 19);
            r = (kind < 10) || (kind == 19);
            w = (kind >= 10);
            f3 = 3'($urandom);
            if ($urandom_range(0, 3) != 0)
                f3 = r ? legal_ld[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            run_txn(r, w, f3, $urandom, $urandom, $urandom_range(0, 5), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit sitting directly downstream of the ALU in the single-cycle RISC-V core. It consumes the ALU result as the effective address, plus rs2 data and funct3. It runs a request/ready handshake with data memory and returns sign- or zero-extended load data to write-back. It stalls the core (PC and register-file write enable) until each access completes, and reports misaligned, illegal and timed-out accesses.

## Interface

**Parameters**
- TIMEOUT, 16: maximum number of cycles spent in REQ before the access is aborted. Legal range 2..256.

**Ports**
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ALUResult  in  32  effective byte address.
- ReadData2  in  32  store data (rs2).
- funct3  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store.
- Stall  out  1  freeze PC and register-file write while high.
- LoadData  out  32  extended load result.
- ErrValid  out  1  one-cycle pulse: access was aborted.
- ErrCode  out  2  01 misaligned, 10 timeout, 11 illegal; held until the next error.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {ALUResult[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word; valid when mem_req && mem_ready.
- mem_ready  in  1  memory accepts/completes the request this cycle.

## Operation

- FSM states IDLE, REQ, DONE; reset state IDLE.
- start = MemRead | MemWrite, evaluated in IDLE only.
- **IDLE**, !start: stay in IDLE, Stall=0.
- **IDLE**, start:
  - Stall=1 (combinational).
  - Illegal cases set ErrCode=11 and go to DONE with no request:
    - MemRead && MemWrite;
    - load funct3 ∈ {011,110,111};
    - store funct3 ∉ {000,001,010}.
  - Misaligned cases set ErrCode=01 and go to DONE with no request:
    - half access with ALUResult[0]=1;
    - word access with ALUResult[1:0]≠00.
  - Otherwise register mem_addr, mem_we, mem_be and mem_wdata, clear the timeout counter, and go to REQ.
- **REQ**:
  - mem_req=1, Stall=1.
  - Address, control and data stay stable until completion.
  - mem_ready=1: if the access is a load, capture the extracted read data into LoadData; go to DONE.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 with no ready, go to DONE with ErrCode=10.
  - Ready on the timeout cycle counts as a normal completion.
- **DONE**:
  - Stall=0 and ErrValid=1 if an error occurred; the core advances on this edge.
  - Always return to IDLE. A start in DONE is ignored, because it belongs to the finishing instruction.
- **Byte enables**:
  - byte: 0001 << addr[1:0];
  - half: addr[1] ? 1100 : 0011;
  - word: 1111.
- **Store data**:
  - byte: {4{rs2[7:0]}};
  - half: {2{rs2[15:0]}};
  - word: rs2.
- **Load extraction**:
  - select the byte lane by addr[1:0] and the half lane by addr[1];
  - lb/lh sign-extend; lbu/lhu zero-extend.
- An aborted load leaves LoadData unchanged. An aborted store issues no write.

## Timing

- Reset values:
  - state IDLE, Stall=0 (with start low), LoadData=0, ErrValid=0, ErrCode=00;
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Reset mid-access: mem_req drops immediately (asynchronous reset) and the in-flight access is discarded.
- Zero-wait memory takes 2 stall cycles: IDLE(start), then REQ with ready. LoadData is valid in DONE.
- N wait states take 2+N stall cycles.
- Timeout: at most TIMEOUT cycles in REQ, so TIMEOUT+1 stall cycles total.
- Error without a request: 1 stall cycle, with ErrValid high in the following DONE cycle.
- LoadData is registered and holds its value until the next successful load.

## Test plan

- **lw, zero-wait memory:** addr 0x100 with mem_rdata=0xDEADBEEF and ready held high. Required: Stall high for 2 cycles, then LoadData=0xDEADBEEF, mem_be=1111, mem_we=0.
- **lb vs lbu:** addr 0x103 with mem_rdata=0x80FF_1234. Required: lb gives 0xFFFFFF80; lbu gives 0x00000080.
- **sh at addr 0x22:** rs2=0x0000ABCD. Required: mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, and request fields stable through 3 wait states (5 stall cycles).
- **Misaligned lw:** addr 0x101. Required: no mem_req, Stall for 1 cycle, ErrValid pulse, ErrCode=01, LoadData unchanged.
- **Timeout with TIMEOUT=4:** mem_ready tied low. Required: mem_req high for exactly 4 cycles, ErrCode=10, FSM back in IDLE.
  - Repeat with ready asserted on the 4th REQ cycle: normal completion, no error.
- **Async reset mid-REQ:** assert rst_n low while a request is outstanding. Required: mem_req=0 and Stall=0 without waiting for a clock edge; the next load after reset completes normally.
